// File: rtl/mdu_pkg.sv
// Shared definitions for the M-extension multiply issue path: funct3 encodings,
// controller state encoding and the default multiplier latency.
package mdu_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  localparam int MDU_MUL_LATENCY = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mdu_issue_ctrl.sv
// Issue/writeback controller for the fixed-latency multiplier: accepts one request,
// launches, counts latency, holds the result for writeback. Option: MDU_FAST_ZERO_EN.
module mdu_issue_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_LATENCY = MDU_MUL_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic        mul_start,
  output logic [2:0]  mul_funct3,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_result,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy
);

  localparam int CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LATENCY - 1);

  mdu_state_t  state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]  f3_reg, f3_next;
  logic [31:0] a_reg, a_next;
  logic [31:0] b_reg, b_next;
  logic [4:0]  rd_reg, rd_next;
  logic [31:0] data_reg, data_next;
  logic        start_reg, start_next;
  logic        valid_reg, valid_next;
  logic        skip_launch;

  // Requests whose answer is known to be zero bypass the multiplier entirely.
`ifdef MDU_FAST_ZERO_EN
  assign skip_launch = req_funct3[2] || (req_a == 32'd0) || (req_b == 32'd0);
`else
  assign skip_launch = req_funct3[2];
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    f3_next    = f3_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    rd_next    = rd_reg;
    data_next  = data_reg;
    start_next = 1'b0;
    valid_next = 1'b0;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            rd_next = req_rd;
            if (skip_launch) begin
              state_next = DONE;
              data_next  = 32'd0;
              valid_next = 1'b1;
            end else begin
              state_next = LAUNCH;
              f3_next    = req_funct3;
              a_next     = req_a;
              b_next     = req_b;
              start_next = 1'b1;
            end
          end
        end
        LAUNCH: begin
          state_next = WAIT;
          cnt_next   = CNT_LOAD;
        end
        WAIT: begin
          if (cnt_reg == '0) begin
            state_next = DONE;
            data_next  = mul_result;
            valid_next = 1'b1;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        DONE: begin
          if (wb_ready) begin
            state_next = IDLE;
          end else begin
            valid_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      f3_reg    <= 3'd0;
      a_reg     <= 32'd0;
      b_reg     <= 32'd0;
      rd_reg    <= 5'd0;
      data_reg  <= 32'd0;
      start_reg <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      f3_reg    <= f3_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      rd_reg    <= rd_next;
      data_reg  <= data_next;
      start_reg <= start_next;
      valid_reg <= valid_next;
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign mul_start  = start_reg;
  assign mul_funct3 = f3_reg;
  assign mul_a      = a_reg;
  assign mul_b      = b_reg;
  assign wb_valid   = valid_reg;
  assign wb_rd      = rd_reg;
  assign wb_data    = data_reg;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Self-checking bench for mdu_issue_ctrl with a behavioural fixed-latency multiplier
// that drives random garbage on mul_result except in the cycle a result is due.
module tb_mdu_issue_ctrl;
  import mdu_pkg::*;

  localparam int L = MDU_MUL_LATENCY;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        mul_start;
  logic [2:0]  mul_funct3;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_result = 32'd0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc = 0;
  logic [31:0] pend [int];

  mdu_issue_ctrl #(.MUL_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .mul_start(mul_start), .mul_funct3(mul_funct3), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RISC-V M-extension product semantics, computed on 64-bit values.
  function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f3)
      3'b000:  begin p = ua * ub; return p[31:0]; end
      3'b001:  begin p = sa * sb; return p[63:32]; end
      3'b010:  begin p = sa * ub; return p[63:32]; end
      3'b011:  begin p = ua * ub; return p[63:32]; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2]) return 1;
`ifdef MDU_FAST_ZERO_EN
    if (a == 32'd0 || b == 32'd0) return 1;
`endif
    return L + 2;
  endfunction

  // Multiplier: result valid exactly L cycles after the mul_start cycle.
  always @(negedge clk) begin
    if (pend.exists(cyc)) begin
      mul_result = pend[cyc];
      pend.delete(cyc);
    end else begin
      mul_result = $urandom;
    end
    if (mul_start === 1'b1) pend[cyc + L] = ref_mul(mul_funct3, mul_a, mul_b);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_req();
    req_valid  = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom);
    req_a      = $urandom;
    req_b      = $urandom;
    req_rd     = 5'($urandom);
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (wb_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1)
      begin errors++; $display("FAIL %s idle: wb_valid=%b busy=%b req_ready=%b want 0 0 1", name, wb_valid, busy, req_ready); end
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int hold, input string name);
    int n, starts, lat;
    logic [31:0] exp_data;
    exp_data = ref_mul(f3, a, b);
    lat = exp_latency(f3, a, b);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL %s req_ready before accept: got %b want 1", name, req_ready); end
    req_valid = 1'b1; req_funct3 = f3; req_a = a; req_b = b; req_rd = rd;
    wb_ready = (hold == 0);
    last_acc = cyc;
    step();
    n = 1; starts = 0;
    while (wb_valid !== 1'b1 && n < 20) begin
      starts += int'(mul_start);
      if (n == 1) begin
        checks++;
        if (mul_start !== (lat > 1)) begin errors++; $display("FAIL %s mul_start at T+1: got %b want %b", name, mul_start, lat > 1); end
      end
      checks++;
      if (busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL %s busy wait n=%0d: busy=%b req_ready=%b", name, n, busy, req_ready); end
      junk_req();
      step();
      n++;
    end
    req_valid = 1'b0;
    checks++;
    if (n !== lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, n, lat); end
    checks++;
    if (starts !== (lat > 1 ? 1 : 0)) begin errors++; $display("FAIL %s mul_start count: got %0d want %0d", name, starts, lat > 1 ? 1 : 0); end
    for (int i = 0; i <= hold; i++) begin
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== exp_data || wb_rd !== rd || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s writeback hold %0d: valid=%b data=%h rd=%0d ready=%b want 1 %h %0d 0", name, i, wb_valid, wb_data, wb_rd, req_ready, exp_data, rd);
      end
      if (i == hold) wb_ready = 1'b1;
      step();
    end
    wb_ready = 1'b0;
    check_idle(name);
    $display("op %s f3=%0d a=%h b=%h rd=%0d -> data=%h lat=%0d", name, f3, a, b, rd, exp_data, n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    junk_req();
    step(); step(); step();
    reset = 1'b0; req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || mul_start !== 1'b0 || wb_valid !== 1'b0 || wb_rd !== 5'd0 ||
        wb_data !== 32'd0 || mul_a !== 32'd0 || mul_b !== 32'd0 || mul_funct3 !== 3'd0) begin
      errors++;
      $display("FAIL reset values: rdy=%b busy=%b start=%b wbv=%b rd=%0d data=%h a=%h b=%h f3=%0d", req_ready, busy, mul_start, wb_valid, wb_rd, wb_data, mul_a, mul_b, mul_funct3);
    end
    $display("reset checked");
  endtask

  task automatic test_reset_midway();
    int n;
    req_valid = 1'b1; req_funct3 = F3_MUL; req_a = 32'd7; req_b = 32'd6; req_rd = 5'd9;
    step();
    req_valid = 1'b0;
    n = 0;
    while (wb_valid !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'd42) begin errors++; $display("FAIL reset_midway setup: valid=%b data=%h want 1 0000002a", wb_valid, wb_data); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (wb_valid !== 1'b0 || wb_data !== 32'd0 || wb_rd !== 5'd0 || mul_a !== 32'd0 || mul_b !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_midway clear: wbv=%b data=%h rd=%0d a=%h b=%h busy=%b", wb_valid, wb_data, wb_rd, mul_a, mul_b, busy);
    end
    $display("reset during DONE checked");
  endtask

  task automatic test_flush(input int k, input int watch, input string name);
    req_valid = 1'b1; req_funct3 = F3_MULH; req_a = 32'h8000_0000; req_b = 32'd2; req_rd = 5'd3;
    wb_ready = 1'b0;
    step();
    req_valid = 1'b0;
    for (int i = 1; i < k; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_idle(name);
    for (int i = 0; i < watch; i++) begin
      checks++;
      if (wb_valid !== 1'b0 || mul_start !== 1'b0) begin errors++; $display("FAIL %s after flush %0d: wb_valid=%b mul_start=%b want 0 0", name, i, wb_valid, mul_start); end
      step();
    end
    $display("flush %s at T+%0d checked", name, k);
  endtask

  task automatic test_flush_idle();
    req_valid = 1'b1; flush = 1'b1; req_funct3 = F3_MUL; req_a = 32'd5; req_b = 32'd5; req_rd = 5'd1;
    step();
    req_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (mul_start !== 1'b0 || busy !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL flush_idle cycle %0d: start=%b busy=%b wbv=%b want 0 0 0", i, mul_start, busy, wb_valid); end
      step();
    end
    $display("request with flush in IDLE dropped");
  endtask

  task automatic test_back_to_back();
    int prev;
    do_op(F3_MUL, 32'd11, 32'd13, 5'd1, 0, "b2b0");
    for (int i = 1; i < 5; i++) begin
      prev = last_acc;
      do_op(3'($urandom_range(0, 3)), $urandom | 32'd1, $urandom | 32'd1, 5'($urandom), 0, "b2b");
      checks++;
      if (last_acc - prev !== L + 3) begin errors++; $display("FAIL b2b spacing: got %0d want %0d", last_acc - prev, L + 3); end
    end
  endtask

  task automatic test_random();
    logic [2:0] f3;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      a = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      do_op(f3, a, b, 5'($urandom), $urandom_range(0, 3), "rand");
    end
  endtask

  task automatic test_random_flush();
    for (int i = 0; i < 8; i++) begin
      test_flush($urandom_range(1, L + 3), 0, "rflush");
      do_op(3'($urandom_range(0, 3)), $urandom | 32'd1, $urandom | 32'd1, 5'($urandom), 0, "post_flush");
    end
  endtask

  initial begin
    test_reset();
    do_op(F3_MUL, 32'd7, 32'd6, 5'd5, 0, "mul_7x6");
    do_op(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 4, "mulhu_hold");
    do_op(F3_MULH, 32'h8000_0000, 32'd2, 5'd4, 0, "mulh_neg");
    test_flush(3, 8, "plan");
    do_op(F3_MUL, 32'd3, 32'd3, 5'd7, 0, "mul_3x3");
    test_flush_idle();
    do_op(3'b100, 32'd9, 32'd9, 5'd2, 0, "illegal");
    do_op(F3_MULHSU, 32'd0, 32'h1234, 5'd8, 0, "zero_a");
    do_op(F3_MULHSU, 32'hFFFF_FFFF, 32'h1234, 5'd8, 1, "mulhsu_neg");
    test_back_to_back();
    test_random_flush();
    test_random();
    test_reset_midway();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
